// File: rtl/change_dispenser.sv
// change_dispenser: greedy coin payout (5/2/1 units) with per-denomination
// tube tracking, completion pulse and shortfall flag.
// Optional audit counters (total_paid, short_events) are enabled by defining
// the macro CHANGE_AUDIT_EN.
// Timing assumes PULSE_WIDTH >= 1 and GAP_WIDTH >= 1.
module change_dispenser #(
    parameter int unsigned PULSE_WIDTH = 25000000,
    parameter int unsigned GAP_WIDTH   = 25000000,
    parameter int unsigned TUBE_INIT   = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       change_start,
    input  logic [7:0] change_amount,
    input  logic       refill,
    output logic       busy,
    output logic       done,
    output logic       short_flag,
    output logic       coin_out5,
    output logic       coin_out2,
    output logic       coin_out1,
    output logic [7:0] remaining,
    output logic [3:0] tube5,
    output logic [3:0] tube2,
    output logic [3:0] tube1
`ifdef CHANGE_AUDIT_EN
    ,
    output logic [15:0] total_paid,
    output logic [7:0]  short_events
`endif
);

    localparam logic [3:0]  TUBE_LOAD  = 4'(TUBE_INIT);
    localparam logic [24:0] PULSE_LOAD = 25'((PULSE_WIDTH > 0) ? PULSE_WIDTH - 1 : 0);
    localparam logic [24:0] GAP_LOAD   = 25'((GAP_WIDTH > 0) ? GAP_WIDTH - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_EJECT,
        S_GAP,
        S_FINISH
    } state_t;

    typedef enum logic [1:0] {
        DEN_1,
        DEN_2,
        DEN_5
    } den_t;

    state_t      r_state;
    den_t        r_sel;
    logic [24:0] r_timer;

    den_t        w_den;
    logic        w_found;
    logic [7:0]  w_sel_val;

`ifdef CHANGE_AUDIT_EN
    logic [16:0] w_paid_sum;
`endif

    // Greedy candidate: largest denomination that fits and is in stock
    always_comb begin
        w_den   = DEN_1;
        w_found = 1'b0;
        if (remaining >= 8'd5 && tube5 != 4'd0) begin
            w_den   = DEN_5;
            w_found = 1'b1;
        end else if (remaining >= 8'd2 && tube2 != 4'd0) begin
            w_den   = DEN_2;
            w_found = 1'b1;
        end else if (remaining >= 8'd1 && tube1 != 4'd0) begin
            w_den   = DEN_1;
            w_found = 1'b1;
        end
    end

    // Unit value of the coin currently being ejected
    always_comb begin
        w_sel_val = 8'd1;
        case (r_sel)
            DEN_5:   w_sel_val = 8'd5;
            DEN_2:   w_sel_val = 8'd2;
            default: w_sel_val = 8'd1;
        endcase
    end

`ifdef CHANGE_AUDIT_EN
    // Widened sum so saturation can be detected from the carry bit
    always_comb begin
        w_paid_sum = {1'b0, total_paid} + {9'd0, w_sel_val};
    end
`endif

    // Payout FSM with registered outputs and tube bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_sel      <= DEN_1;
            r_timer    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            short_flag <= 1'b0;
            coin_out5  <= 1'b0;
            coin_out2  <= 1'b0;
            coin_out1  <= 1'b0;
            remaining  <= '0;
            tube5      <= TUBE_LOAD;
            tube2      <= TUBE_LOAD;
            tube1      <= TUBE_LOAD;
`ifdef CHANGE_AUDIT_EN
            total_paid   <= '0;
            short_events <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (refill) begin
                        tube5 <= TUBE_LOAD;
                        tube2 <= TUBE_LOAD;
                        tube1 <= TUBE_LOAD;
                    end
                    if (change_start) begin
                        remaining  <= change_amount;
                        short_flag <= 1'b0;
                        busy       <= 1'b1;
                        r_state    <= S_SELECT;
                    end
                end

                S_SELECT: begin
                    if (remaining == 8'd0) begin
                        done    <= 1'b1;
                        r_state <= S_FINISH;
                    end else if (w_found) begin
                        r_sel     <= w_den;
                        r_timer   <= PULSE_LOAD;
                        coin_out5 <= (w_den == DEN_5);
                        coin_out2 <= (w_den == DEN_2);
                        coin_out1 <= (w_den == DEN_1);
                        r_state   <= S_EJECT;
                    end else begin
                        short_flag <= 1'b1;
                        done       <= 1'b1;
                        r_state    <= S_FINISH;
`ifdef CHANGE_AUDIT_EN
                        if (short_events != 8'hFF) begin
                            short_events <= short_events + 8'd1;
                        end
`endif
                    end
                end

                S_EJECT: begin
                    if (r_timer == '0) begin
                        coin_out5 <= 1'b0;
                        coin_out2 <= 1'b0;
                        coin_out1 <= 1'b0;
                        remaining <= remaining - w_sel_val;
                        case (r_sel)
                            DEN_5:   if (tube5 != 4'd0) tube5 <= tube5 - 4'd1;
                            DEN_2:   if (tube2 != 4'd0) tube2 <= tube2 - 4'd1;
                            default: if (tube1 != 4'd0) tube1 <= tube1 - 4'd1;
                        endcase
`ifdef CHANGE_AUDIT_EN
                        total_paid <= w_paid_sum[16] ? 16'hFFFF : w_paid_sum[15:0];
`endif
                        r_timer <= GAP_LOAD;
                        r_state <= S_GAP;
                    end else begin
                        r_timer <= r_timer - 25'd1;
                    end
                end

                S_GAP: begin
                    if (r_timer == '0) begin
                        r_state <= S_SELECT;
                    end else begin
                        r_timer <= r_timer - 25'd1;
                    end
                end

                S_FINISH: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
